flag_register_stack: RTL and testbench

- Parametrised successor of the datapath status-flag register.
- Holds NUM_FLAGS live flags, each updated under an independent per-flag write mask, so the control unit drives a mask instead of the register decoding opcodes.
- Adds a LIFO save/restore stack, STACK_DEPTH entries, for CALL/RET and interrupt entry/exit.
- Sits between the ALU flag outputs and the branch-condition logic.

---
 rtl/flag_register_stack_if.sv | 44 ++++
 rtl/flag_register_stack.sv | 97 +++++++++
 tb/tb_flag_register_stack.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/flag_register_stack_if.sv
// Bus between the control unit and the flag register stack.
// ov_sticky / ov_clr exist only when FLAG_STICKY_OV_EN is defined.
interface flag_register_stack_if #(
  parameter int NUM_FLAGS = 4,
  parameter int CNT_W     = 3
);
  logic [NUM_FLAGS-1:0] flags_in;
  logic [NUM_FLAGS-1:0] flag_we;
  logic                 update_en;
  logic                 push;
  logic                 pop;
  logic [NUM_FLAGS-1:0] flags_out;
  logic [CNT_W-1:0]     stack_count;
  logic                 stack_full;
  logic                 stack_empty;
  logic                 stack_err;
`ifdef FLAG_STICKY_OV_EN
  logic                 ov_clr;
  logic                 ov_sticky;
`endif

  // No valid/ready handshake: push, pop and update_en are single-cycle
  // commands, always accepted; an illegal stack command is reported on
  // stack_err the following cycle and otherwise ignored.
`ifdef FLAG_STICKY_OV_EN
  modport master (
    output flags_in, flag_we, update_en, push, pop, ov_clr,
    input  flags_out, stack_count, stack_full, stack_empty, stack_err, ov_sticky
  );
  modport slave (
    input  flags_in, flag_we, update_en, push, pop, ov_clr,
    output flags_out, stack_count, stack_full, stack_empty, stack_err, ov_sticky
  );
`else
  modport master (
    output flags_in, flag_we, update_en, push, pop,
    input  flags_out, stack_count, stack_full, stack_empty, stack_err
  );
  modport slave (
    input  flags_in, flag_we, update_en, push, pop,
    output flags_out, stack_count, stack_full, stack_empty, stack_err
  );
`endif
endinterface

// File: rtl/flag_register_stack.sv
// Masked status-flag register with a LIFO save/restore stack for CALL/RET.
// Optional sticky overflow flag enabled by defining FLAG_STICKY_OV_EN.
module flag_register_stack #(
  parameter int NUM_FLAGS   = 4,
  parameter int STACK_DEPTH = 4,
  parameter int CNT_W       = $clog2(STACK_DEPTH + 1)
) (
  input logic                  clock,
  input logic                  reset,
  flag_register_stack_if.slave bus
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [NUM_FLAGS-1:0] flags_q;
  logic [NUM_FLAGS-1:0] stack_mem [STACK_DEPTH];
  logic [CNT_W-1:0]     count_q;
  logic                 err_q;

  logic                 full;
  logic                 empty;
  logic                 do_push;
  logic                 do_pop;
  logic                 bad_op;
  logic [CNT_W-1:0]     rd_cnt;
  logic [IDX_W-1:0]     wr_idx;
  logic [IDX_W-1:0]     rd_idx;
  logic [NUM_FLAGS-1:0] pop_val;
  logic [NUM_FLAGS-1:0] upd_val;
  logic [NUM_FLAGS-1:0] flags_next;

  always_comb begin
    full    = (count_q == CNT_W'(STACK_DEPTH));
    empty   = (count_q == '0);
    do_push = bus.push && !bus.pop && !full;
    do_pop  = bus.pop && !bus.push && !empty;
    bad_op  = (bus.push && bus.pop) ||
              (bus.push && full) ||
              (bus.pop && empty);
    rd_cnt  = count_q - CNT_W'(1);
    wr_idx  = count_q[IDX_W-1:0];
    rd_idx  = rd_cnt[IDX_W-1:0];
    pop_val = stack_mem[rd_idx];
    upd_val = bus.update_en ? ((bus.flag_we & bus.flags_in) | (~bus.flag_we & flags_q))
                            : flags_q;
    // A legal restore wins over the live write in the same cycle.
    flags_next = do_pop ? pop_val : upd_val;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      flags_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_next;
      err_q   <= bad_op;
      if (do_push)
        count_q <= count_q + CNT_W'(1);
      else if (do_pop)
        count_q <= rd_cnt;
    end
  end

  // Stack contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clock) begin
    if (!reset && do_push)
      stack_mem[wr_idx] <= flags_q;
  end

`ifdef FLAG_STICKY_OV_EN
  logic ov_q;
  logic ov_set;

  always_comb begin
    ov_set = do_pop ? pop_val[3] : (bus.update_en && bus.flag_we[3] && bus.flags_in[3]);
  end

  always_ff @(posedge clock) begin
    if (reset)
      ov_q <= 1'b0;
    else if (ov_set)
      ov_q <= 1'b1;
    else if (bus.ov_clr)
      ov_q <= 1'b0;
  end

  assign bus.ov_sticky = ov_q;
`endif

  assign bus.flags_out   = flags_q;
  assign bus.stack_count = count_q;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.stack_err   = err_q;

endmodule

// File: tb/tb_flag_register_stack.sv
// Directed bench for flag_register_stack (NUM_FLAGS=4, STACK_DEPTH=4).
// Exercises the sticky overflow flag when FLAG_STICKY_OV_EN is defined.
module tb_flag_register_stack;

  localparam int NF = 4;
  localparam int SD = 4;
  localparam int CW = 3;

  logic clock;
  logic reset;
  int   total_checks;
  int   passed_checks;
  int   failed_checks;

  flag_register_stack_if #(.NUM_FLAGS(NF), .CNT_W(CW)) bus ();

  flag_register_stack #(.NUM_FLAGS(NF), .STACK_DEPTH(SD), .CNT_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // driver tasks
  task automatic drive(input logic ue, input logic [NF-1:0] we, input logic [NF-1:0] fin,
                       input logic ps, input logic pp);
    bus.update_en = ue;
    bus.flag_we   = we;
    bus.flags_in  = fin;
    bus.push      = ps;
    bus.pop       = pp;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    assert (obs === exp) passed_checks++;
    else begin
      failed_checks++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [NF-1:0] f, input int cnt,
                             input logic err);
    check({tag, ".flags"}, 32'(bus.flags_out), 32'(f));
    check({tag, ".count"}, 32'(bus.stack_count), 32'(cnt));
    check({tag, ".err"},   32'(bus.stack_err), 32'(err));
    check({tag, ".full"},  32'(bus.stack_full), 32'(cnt == SD));
    check({tag, ".empty"}, 32'(bus.stack_empty), 32'(cnt == 0));
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    failed_checks = 0;
    reset = 1'b1;
    idle();
`ifdef FLAG_STICKY_OV_EN
    bus.ov_clr = 1'b0;
`endif
    step();
    step();
    reset = 1'b0;
    check_state("reset", 4'b0000, 0, 1'b0);

    // masked update
    drive(1'b1, 4'b0101, 4'b1111, 1'b0, 1'b0); step();
    check_state("upd_mask", 4'b0101, 0, 1'b0);
    drive(1'b1, 4'b0000, 4'b1010, 1'b0, 1'b0); step();
    check_state("upd_hold", 4'b0101, 0, 1'b0);
    drive(1'b0, 4'b1111, 4'b1010, 1'b0, 1'b0); step();
    check_state("upd_en_off", 4'b0101, 0, 1'b0);

    // push/pop round trip with same-cycle update
    drive(1'b1, 4'b1111, 4'b1010, 1'b0, 1'b0); step();
    drive(1'b1, 4'b1111, 4'b0001, 1'b1, 1'b0); step();
    check_state("push_upd", 4'b0001, 1, 1'b0);
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1); step();
    check_state("pop_back", 4'b1010, 0, 1'b0);

    // pop overrides update
    drive(1'b1, 4'b1111, 4'b0110, 1'b0, 1'b0); step();
    drive(1'b1, 4'b1111, 4'b0000, 1'b1, 1'b0); step();
    check_state("push_0110", 4'b0000, 1, 1'b0);
    drive(1'b1, 4'b1111, 4'b1111, 1'b0, 1'b1); step();
    check_state("pop_over_upd", 4'b0110, 0, 1'b0);

    // overflow: 0001 is the first value pushed
    drive(1'b1, 4'b1111, 4'b0001, 1'b0, 1'b0); step();
    drive(1'b1, 4'b1111, 4'b0010, 1'b1, 1'b0); step();
    check_state("push1", 4'b0010, 1, 1'b0);
    drive(1'b1, 4'b1111, 4'b0100, 1'b1, 1'b0); step();
    check_state("push2", 4'b0100, 2, 1'b0);
    drive(1'b1, 4'b1111, 4'b1000, 1'b1, 1'b0); step();
    check_state("push3", 4'b1000, 3, 1'b0);
    drive(1'b1, 4'b1111, 4'b1100, 1'b1, 1'b0); step();
    check_state("push4", 4'b1100, 4, 1'b0);
    drive(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0); step();
    check_state("push5_full", 4'b1111, 4, 1'b1);
    idle(); step();
    check_state("err_clear1", 4'b1111, 4, 1'b0);

    // underflow
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1); step();
    check_state("pop1", 4'b1000, 3, 1'b0);
    step();
    check_state("pop2", 4'b0100, 2, 1'b0);
    step();
    check_state("pop3", 4'b0010, 1, 1'b0);
    step();
    check_state("pop4", 4'b0001, 0, 1'b0);
    step();
    check_state("pop5_empty", 4'b0001, 0, 1'b1);
    idle(); step();
    check_state("err_clear2", 4'b0001, 0, 1'b0);

    // pop when empty still applies the update
    drive(1'b1, 4'b0010, 4'b0010, 1'b0, 1'b1); step();
    check_state("pop_empty_upd", 4'b0011, 0, 1'b1);

    // simultaneous push and pop at count 2
    drive(1'b1, 4'b1111, 4'b0001, 1'b0, 1'b0); step();
    drive(1'b1, 4'b1111, 4'b0011, 1'b1, 1'b0); step();
    drive(1'b1, 4'b1111, 4'b0111, 1'b1, 1'b0); step();
    check_state("build2", 4'b0111, 2, 1'b0);
    drive(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1); step();
    check_state("push_pop", 4'b0111, 2, 1'b1);
    drive(1'b1, 4'b1000, 4'b1000, 1'b1, 1'b1); step();
    check_state("push_pop_upd", 4'b1111, 2, 1'b1);
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1); step();
    check_state("pop_after_pp", 4'b0011, 1, 1'b0);

    // reset mid-stack together with pop
    drive(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0); step();
    step();
    check_state("build3", 4'b0011, 3, 1'b0);
    reset = 1'b1;
    drive(1'b1, 4'b1111, 4'b1111, 1'b0, 1'b1); step();
    reset = 1'b0;
    idle();
    check_state("reset_pop", 4'b0000, 0, 1'b0);

`ifdef FLAG_STICKY_OV_EN
    check("ov_reset", 32'(bus.ov_sticky), 32'd0);
    drive(1'b1, 4'b1000, 4'b1000, 1'b0, 1'b0); step();
    check("ov_set", 32'(bus.ov_sticky), 32'd1);
    drive(1'b1, 4'b1000, 4'b0000, 1'b0, 1'b0); step();
    check("ov_hold", 32'(bus.ov_sticky), 32'd1);
    check("ov_hold.flags", 32'(bus.flags_out), 32'h0);
    idle(); bus.ov_clr = 1'b1; step();
    check("ov_clr", 32'(bus.ov_sticky), 32'd0);
    drive(1'b1, 4'b1000, 4'b1000, 1'b0, 1'b0); step();
    check("ov_set_wins", 32'(bus.ov_sticky), 32'd1);
    // restore of O=1 by pop also sets it
    drive(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0); step();
    drive(1'b1, 4'b1000, 4'b0000, 1'b0, 1'b0); step();
    check("ov_clr2", 32'(bus.ov_sticky), 32'd0);
    bus.ov_clr = 1'b0;
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1); step();
    check("ov_pop_set", 32'(bus.ov_sticky), 32'd1);
    check("ov_pop.flags", 32'(bus.flags_out), 32'h8);
    idle();
`endif

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
